// File: rtl/tcm_port_arb.sv
// Two-requester arbiter sharing one TCM RAM port between the CPU data path (port 0) and AXI/DMA (port 1).
// Define TCM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority to port 0 with an anti-starvation counter.
module tcm_port_arb #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    input  logic [12:0] req0_addr_i,
    input  logic [63:0] req0_data_i,
    input  logic [7:0]  req0_wr_i,
    output logic        req0_accept_o,
    output logic        resp0_valid_o,
    output logic [63:0] resp0_data_o,
    input  logic        req1_valid_i,
    input  logic [12:0] req1_addr_i,
    input  logic [63:0] req1_data_i,
    input  logic [7:0]  req1_wr_i,
    output logic        req1_accept_o,
    output logic        resp1_valid_o,
    output logic [63:0] resp1_data_o,
    output logic [12:0] ram_addr_o,
    output logic [63:0] ram_data_o,
    output logic [7:0]  ram_wr_o,
    input  logic [63:0] ram_data_i
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
        $error("tcm_port_arb: STARVE_LIMIT must be in 1..15");
    end

    logic grant0;
    logic grant1;
    logic pending_q, pending_d;
    logic owner_q, owner_d;

`ifdef TCM_ARB_RR_EN
    logic last_q, last_d;

    // Under contention the port that did not win the previous grant goes first.
    always_comb begin
        grant1 = req1_valid_i && (!req0_valid_i || !last_q);
        grant0 = req0_valid_i && !grant1;
        last_d = last_q;
        if (grant0) begin
            last_d = 1'b0;
        end else if (grant1) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    logic [3:0] starve_q, starve_d;

    // Port 0 wins contests until port 1 has lost STARVE_LIMIT in a row.
    always_comb begin
        grant1   = req1_valid_i && (!req0_valid_i || (starve_q == 4'(STARVE_LIMIT)));
        grant0   = req0_valid_i && !grant1;
        starve_d = starve_q;
        if (grant1) begin
            starve_d = 4'd0;
        end else if (req1_valid_i) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    always_comb begin
        req0_accept_o = grant0;
        req1_accept_o = grant1;
        ram_addr_o    = 13'd0;
        ram_data_o    = 64'd0;
        ram_wr_o      = 8'd0;
        if (grant1) begin
            ram_addr_o = req1_addr_i;
            ram_data_o = req1_data_i;
            ram_wr_o   = req1_wr_i;
        end else if (grant0) begin
            ram_addr_o = req0_addr_i;
            ram_data_o = req0_data_i;
            ram_wr_o   = req0_wr_i;
        end
        pending_d = grant0 || grant1;
        owner_d   = grant1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= 1'b0;
            owner_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            owner_q   <= owner_d;
        end
    end

    // RAM read data is returned one cycle after the grant to whichever port owned it.
    always_comb begin
        resp0_valid_o = pending_q && !owner_q;
        resp1_valid_o = pending_q && owner_q;
        resp0_data_o  = resp0_valid_o ? ram_data_i : 64'd0;
        resp1_data_o  = resp1_valid_o ? ram_data_i : 64'd0;
    end

endmodule

// File: tb/tb_tcm_port_arb.sv
// Randomized self-checking bench for tcm_port_arb with a read-first RAM model and a rule-level arbitration model.
module tb_tcm_port_arb;

    localparam int STARVE_LIMIT = 4;

    logic        clk, rst;
    logic        req0_valid, req1_valid;
    logic [12:0] req0_addr, req1_addr;
    logic [63:0] req0_data, req1_data;
    logic [7:0]  req0_wr, req1_wr;
    logic        accept0, accept1;
    logic        resp0_valid, resp1_valid;
    logic [63:0] resp0_data, resp1_data;
    logic [12:0] ram_addr;
    logic [63:0] ram_wdata;
    logic [7:0]  ram_wr;
    logic [63:0] ram_rdata;

    int checks = 0;
    int failures = 0;

    tcm_port_arb #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(req0_valid), .req0_addr_i(req0_addr), .req0_data_i(req0_data),
        .req0_wr_i(req0_wr), .req0_accept_o(accept0),
        .resp0_valid_o(resp0_valid), .resp0_data_o(resp0_data),
        .req1_valid_i(req1_valid), .req1_addr_i(req1_addr), .req1_data_i(req1_data),
        .req1_wr_i(req1_wr), .req1_accept_o(accept1),
        .resp1_valid_o(resp1_valid), .resp1_data_o(resp1_data),
        .ram_addr_o(ram_addr), .ram_data_o(ram_wdata), .ram_wr_o(ram_wr),
        .ram_data_i(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first RAM macro stand-in
    bit [63:0] ram_mem [0:8191];
    initial ram_rdata = 64'd0;
    always @(posedge clk) begin
        ram_rdata <= ram_mem[ram_addr];
        for (int b = 0; b < 8; b++)
            if (ram_wr[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end

    // Reference model state
    bit [63:0] model_mem [0:8191];
    int        losses;
    int        last_winner;
    bit        exp_pend;
    int        exp_port;
    bit [63:0] exp_rdata;
    bit        last_g0, last_g1;
    int        grants1;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        losses      = 0;
        last_winner = 1;
        exp_pend    = 1'b0;
        exp_port    = 0;
        exp_rdata   = 64'd0;
    endtask

    task automatic applyStimulus(input int port);
        bit        v;
        bit [12:0] a;
        bit [63:0] d;
        bit [7:0]  w;
        v = ($urandom_range(0, 3) != 0);
        a = 13'($urandom_range(0, 15));
        d = {$urandom, $urandom};
        w = ($urandom_range(0, 1) == 1) ? 8'd0 : 8'($urandom);
        if (port == 0) begin
            req0_valid = v; req0_addr = a; req0_data = d; req0_wr = w;
        end else begin
            req1_valid = v; req1_addr = a; req1_data = d; req1_wr = w;
        end
    endtask

    // One clock cycle: check at negedge against the model, advance the model, return just after posedge.
    task automatic doCycle();
        int        winner;
        bit [12:0] a;
        bit [63:0] d;
        bit [7:0]  w;
        bit [63:0] exp_wdata;
        bit [12:0] exp_addr;
        bit [7:0]  exp_wr;
        @(negedge clk);
        if (req0_valid && req1_valid) begin
`ifdef TCM_ARB_RR_EN
            winner = 1 - last_winner;
`else
            winner = (losses == STARVE_LIMIT) ? 1 : 0;
`endif
        end else if (req0_valid) winner = 0;
        else if (req1_valid)     winner = 1;
        else                     winner = -1;

        exp_addr = 13'd0; exp_wdata = 64'd0; exp_wr = 8'd0;
        if (winner == 0) begin exp_addr = req0_addr; exp_wdata = req0_data; exp_wr = req0_wr; end
        if (winner == 1) begin exp_addr = req1_addr; exp_wdata = req1_data; exp_wr = req1_wr; end

        checkOutput("accept0", 64'(accept0), 64'(winner == 0));
        checkOutput("accept1", 64'(accept1), 64'(winner == 1));
        checkOutput("ram_addr", 64'(ram_addr), 64'(exp_addr));
        checkOutput("ram_wr", 64'(ram_wr), 64'(exp_wr));
        checkOutput("ram_wdata", ram_wdata, exp_wdata);
        checkOutput("resp0_valid", 64'(resp0_valid), 64'(exp_pend && exp_port == 0));
        checkOutput("resp1_valid", 64'(resp1_valid), 64'(exp_pend && exp_port == 1));
        checkOutput("resp0_data", resp0_data, (exp_pend && exp_port == 0) ? exp_rdata : 64'd0);
        checkOutput("resp1_data", resp1_data, (exp_pend && exp_port == 1) ? exp_rdata : 64'd0);

        last_g0 = (winner == 0);
        last_g1 = (winner == 1);
        exp_pend = (winner >= 0);
        if (winner >= 0) begin
            a = exp_addr; d = exp_wdata; w = exp_wr;
            exp_port  = winner;
            exp_rdata = model_mem[a];
            for (int b = 0; b < 8; b++)
                if (w[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
            last_winner = winner;
        end
        if (winner == 1) begin
            grants1++;
            losses = 0;
        end else if (req1_valid) begin
            losses++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    // Asserts reset just after an edge, checks outputs drop at once, releases on a negedge.
    task automatic doReset();
        rst = 1'b1;
        idleInputs();
        #1;
        checkOutput("rst_resp0_valid", 64'(resp0_valid), 64'd0);
        checkOutput("rst_resp1_valid", 64'(resp1_valid), 64'd0);
        checkOutput("rst_resp1_data", resp1_data, 64'd0);
        checkOutput("rst_accept1", 64'(accept1), 64'd0);
        checkOutput("rst_ram_wr", 64'(ram_wr), 64'd0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_hold_resp1_valid", 64'(resp1_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 0; req0_addr = 0; req0_data = 0; req0_wr = 0;
        req1_valid = 0; req1_addr = 0; req1_data = 0; req1_wr = 0;
        grants1 = 0;
        modelReset();
        #2;
        doReset();

        // Port 0 alone: full write, then read back
        req0_valid = 1; req0_addr = 13'h010; req0_data = 64'hDEADBEEF_CAFEF00D; req0_wr = 8'hFF;
        doCycle();
        req0_wr = 8'h00;
        doCycle();
        checkOutput("p0_read_data", resp0_data, 64'hDEADBEEF_CAFEF00D);
        idleInputs();
        doCycle();

        // Partial byte strobes over an all-ones word
        req0_valid = 1; req0_addr = 13'h020; req0_data = 64'hFFFFFFFF_FFFFFFFF; req0_wr = 8'hFF;
        doCycle();
        req0_data = 64'h11223344_55667788; req0_wr = 8'h0F;
        doCycle();
        req0_wr = 8'h00;
        doCycle();
        checkOutput("strobe_read_data", resp0_data, 64'hFFFFFFFF_55667788);
        idleInputs();
        doCycle();

        // Continuous contention for 20 cycles
        doReset();
        grants1 = 0;
        req0_valid = 1; req0_addr = 13'h100; req0_wr = 8'h00;
        req1_valid = 1; req1_addr = 13'h200; req1_wr = 8'h00;
        repeat (20) doCycle();
`ifdef TCM_ARB_RR_EN
        checkOutput("contend_grants1", 64'(grants1), 64'd10);
`else
        checkOutput("contend_grants1", 64'(grants1), 64'd4);
`endif
        idleInputs();
        doCycle();

        // Reset in the cycle after a port 1 read accept
        req1_valid = 1; req1_addr = 13'h020; req1_wr = 8'h00;
        doCycle();
        doReset();
        repeat (2) doCycle();

        // Randomized traffic with requesters holding until accepted
        applyStimulus(0);
        applyStimulus(1);
        for (int i = 0; i < 500; i++) begin
            doCycle();
            if (last_g0 || !req0_valid) applyStimulus(0);
            if (last_g1 || !req1_valid) applyStimulus(1);
        end
        idleInputs();
        repeat (2) doCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
